// File: rtl/mem_arb_pkg.sv
// Shared sizes and FSM state type for the round-robin memory arbiter.
package mem_arb_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and MEM-side bus of the arbiter.
// The arbiter takes the slave view; requesters and the memory sit on the master view.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W
);
    import mem_arb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_din;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_din;
    logic [DATA_W-1:0]         mem_dout;

    modport slave (
        input  req, req_we, req_addr, req_din, mem_dout,
        output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req, req_we, req_addr, req_din, mem_dout,
        input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from the top index back to 0.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic [NUM_REQ-1:0] upper;
    logic [NUM_REQ-1:0] pool;

    // Requests at or above ptr take precedence; otherwise wrap to the full set.
    assign upper = req & ({NUM_REQ{1'b1}} << ptr);
    assign pool  = (|upper) ? upper : req;

    always_comb begin
        win     = '0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pool[i]) begin
                win     = '0;
                win[i]  = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NUM_REQ requesters onto one single-port synchronous MEM.
//   state | meaning
//   IDLE  | arbitrate; latch winner command when any req is present
//   ISSUE | drive MEM from latched command, pulse gnt, advance rr_ptr
//   RDATA | MEM read data is on mem_dout; pulse rvalid to the winner
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
    parameter int DATA_W  = mem_arb_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    import mem_arb_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t           state;
    arb_state_t           state_nxt;

    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     win_idx_q;
    logic [NUM_REQ-1:0]   win_q;
    logic                 cmd_we;
    logic [ADDR_W-1:0]    cmd_addr;
    logic [DATA_W-1:0]    cmd_din;

    logic [NUM_REQ-1:0]   pick_win;
    logic [IDX_W-1:0]     pick_idx;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_din;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .win     (pick_win),
        .win_idx (pick_idx)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                sel_we   = bus.req_we[i];
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_din  = bus.req_din[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs come only from state and latched regs, so reset clears them at once.
    always_comb begin
        state_nxt    = state;
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = cmd_addr;
        bus.mem_din  = cmd_din;
        bus.gnt      = '0;
        bus.rvalid   = '0;
        bus.rdata    = bus.mem_dout;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_en = 1'b1;
                bus.mem_we = cmd_we;
                bus.gnt    = win_q;
                state_nxt  = cmd_we ? IDLE : RDATA;
            end
            RDATA: begin
                bus.rvalid = win_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            win_idx_q <= '0;
            win_q     <= '0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_din   <= '0;
        end else begin
            if ((state == IDLE) && (|bus.req)) begin
                win_idx_q <= pick_idx;
                win_q     <= pick_win;
                cmd_we    <= sel_we;
                cmd_addr  <= sel_addr;
                cmd_din   <= sel_din;
            end
            if (state == ISSUE) begin
                rr_ptr <= (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a behavioural 32x8 MEM and a transaction-level reference model.
module tb_mem_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 8;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // MEM: single-port synchronous, read data appears after the enabling edge
    logic [DW-1:0] mem_arr [32] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout <= mem_arr[bus.mem_addr];
        end
    end

    int            n_checks = 0;
    int            n_fail   = 0;
    cmd_t          q0[$];
    cmd_t          q1[$];
    logic [DW-1:0] ref_mem [32] = '{default: '0};
    int            cyc       = 0;
    int            next_free = 0;
    int            last_w    = NREQ - 1;
    logic [NREQ-1:0] exp_gnt [8];
    logic [NREQ-1:0] exp_rv  [8];
    logic [DW-1:0]   exp_rd  [8];
    bit            pw_valid;
    logic [AW-1:0] pw_addr;
    logic [DW-1:0] pw_din;
    int            rst_mode  = 0;
    bit            rst_fired = 1'b0;
    bit            prev_gnt_read = 1'b0;
    bit            glitch = 1'b0;
    int            gnt_log[$];
    int            rd_log[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic cmd_t mk(input bit we, input int a, input int d);
        cmd_t c;
        c.we   = we;
        c.addr = a[AW-1:0];
        c.din  = d[DW-1:0];
        return c;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic cmd_t q_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_push(input int i, input cmd_t c);
        if (i == 0) q0.push_back(c);
        else        q1.push_back(c);
    endtask

    task automatic q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    function automatic int log_at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Round robin: first requester after the previous winner, wrapping.
    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_w    = NREQ - 1;
        next_free = 0;
        pw_valid  = 1'b0;
        for (int s = 0; s < 8; s++) begin
            exp_gnt[s] = '0;
            exp_rv[s]  = '0;
        end
    endtask

    task automatic check_async(input string tag);
        check_val({tag, "_gnt"},      32'(bus.gnt),      32'h0);
        check_val({tag, "_rvalid"},   32'(bus.rvalid),   32'h0);
        check_val({tag, "_mem_en"},   32'(bus.mem_en),   32'h0);
        check_val({tag, "_mem_we"},   32'(bus.mem_we),   32'h0);
        check_val({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'h0);
        check_val({tag, "_mem_din"},  32'(bus.mem_din),  32'h0);
    endtask

    task automatic drive_inputs();
        cmd_t c;
        logic [NREQ-1:0]    r;
        logic [NREQ-1:0]    w;
        logic [NREQ*AW-1:0] a;
        logic [NREQ*DW-1:0] d;
        r = '0; w = '0; a = '0; d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (q_size(i) > 0) begin
                c             = q_front(i);
                r[i]          = 1'b1;
                w[i]          = c.we;
                a[i*AW +: AW] = c.addr;
                d[i*DW +: DW] = c.din;
            end
        end
        bus.req      = r;
        bus.req_we   = w;
        bus.req_addr = a;
        bus.req_din  = d;
    endtask

    task automatic run_cycle();
        int w;
        int s;
        cmd_t c;
        logic [NREQ-1:0] g;
        drive_inputs();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            if (pw_valid) begin
                ref_mem[pw_addr] = pw_din;
                pw_valid = 1'b0;
            end
            if (cyc >= next_free && (|bus.req)) begin
                w      = rr_winner(bus.req, last_w);
                c.we   = bus.req_we[w];
                c.addr = bus.req_addr[w*AW +: AW];
                c.din  = bus.req_din[w*DW +: DW];
                exp_gnt[cyc % 8] = NREQ'(1) << w;
                if (c.we) begin
                    pw_valid  = 1'b1;
                    pw_addr   = c.addr;
                    pw_din    = c.din;
                    next_free = cyc + 2;
                end else begin
                    exp_rv[(cyc + 1) % 8] = NREQ'(1) << w;
                    exp_rd[(cyc + 1) % 8] = ref_mem[c.addr];
                    next_free = cyc + 3;
                end
                last_w = w;
            end
            if (glitch) begin
                glitch = 1'b0;
                #1 bus.req = '0;
            end
            if (rst_mode == 2 && prev_gnt_read) begin
                #1 rst_n = 1'b0;
                model_reset();
                rst_mode  = 0;
                rst_fired = 1'b1;
                #1 check_async("rdata_rst");
            end
        end
        @(negedge clk);
        s = cyc % 8;
        g = bus.gnt;
        check_val("gnt", 32'(g), 32'(exp_gnt[s]));
        check_val("rvalid", 32'(bus.rvalid), 32'(exp_rv[s]));
        if (exp_rv[s] != '0) check_val("rdata", 32'(bus.rdata), 32'(exp_rd[s]));
        exp_gnt[s] = '0;
        exp_rv[s]  = '0;
        if (bus.rvalid != '0) rd_log.push_back(int'(bus.rdata));
        prev_gnt_read = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                gnt_log.push_back(i);
                if (q_size(i) > 0) begin
                    c = q_front(i);
                    prev_gnt_read = !c.we;
                    q_pop(i);
                end
            end
        end
        if (rst_mode == 1 && g != '0) begin
            rst_n = 1'b0;
            model_reset();
            rst_mode  = 0;
            rst_fired = 1'b1;
            #1 check_async("issue_rst");
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
            run_cycle();
            n++;
        end
        check_val("drain_done", 32'(q0.size() + q1.size()), 32'h0);
        repeat (3) run_cycle();
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1 check_async(tag);
        repeat (2) run_cycle();
        rst_n = 1'b1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        rd_log.delete();
    endtask

    initial begin
        bus.req      = '0;
        bus.req_we   = '0;
        bus.req_addr = '0;
        bus.req_din  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_async("por");
        rst_n = 1'b1;

        // Reset during ISSUE of a write: write must not land, pointer returns to 0
        q_push(0, mk(1, 10, 8'h5A));
        drain(20);
        rst_mode = 1; rst_fired = 1'b0;
        q_push(1, mk(1, 9, 8'h99));
        drain(20);
        check_val("t1_rst_fired", 32'(rst_fired), 32'h1);
        rst_n = 1'b1;
        clear_logs();
        q_push(0, mk(1, 11, 8'h01));
        q_push(1, mk(1, 12, 8'h02));
        drain(20);
        check_val("t1_first_winner", 32'(log_at(gnt_log, 0)), 32'h0);
        check_val("t1_second_winner", 32'(log_at(gnt_log, 1)), 32'h1);
        clear_logs();
        q_push(0, mk(0, 9, 0));
        q_push(0, mk(0, 10, 0));
        drain(20);
        check_val("t1_addr9_unwritten", 32'(log_at(rd_log, 0)), 32'h00);
        check_val("t1_addr10", 32'(log_at(rd_log, 1)), 32'h5A);

        // Single write then read
        clear_logs();
        q_push(0, mk(1, 5, 8'hA5));
        q_push(0, mk(0, 5, 0));
        drain(20);
        check_val("t2_rdata", 32'(log_at(rd_log, 0)), 32'hA5);

        // Contention with both held: grants alternate starting at requester 0
        q_push(1, mk(0, 2, 0));
        drain(20);
        clear_logs();
        q_push(0, mk(1, 1, 8'h11)); q_push(0, mk(1, 1, 8'h11));
        q_push(1, mk(1, 2, 8'h22)); q_push(1, mk(1, 2, 8'h22));
        drain(40);
        for (int i = 0; i < 4; i++) check_val("t3_alt", 32'(log_at(gnt_log, i)), 32'(i % 2));
        clear_logs();
        q_push(0, mk(0, 1, 0));
        q_push(1, mk(0, 2, 0));
        drain(20);
        check_val("t3_rd_r0", 32'(log_at(rd_log, 0)), 32'h11);
        check_val("t3_rd_r1", 32'(log_at(rd_log, 1)), 32'h22);

        // Address wrap: top and bottom words are distinct
        clear_logs();
        q_push(0, mk(1, 0, 8'h0C));
        q_push(0, mk(1, 31, 8'hFF));
        q_push(0, mk(1, 3, 8'h77));
        q_push(0, mk(0, 31, 0));
        q_push(0, mk(0, 0, 0));
        drain(40);
        check_val("t4_rd31", 32'(log_at(rd_log, 0)), 32'hFF);
        check_val("t4_rd0", 32'(log_at(rd_log, 1)), 32'h0C);

        // Read/write race on the same address with requester 0 winning
        pulse_reset("idle_rst");
        clear_logs();
        q_push(0, mk(0, 3, 0)); q_push(0, mk(0, 3, 0));
        q_push(1, mk(1, 3, 8'h3C));
        drain(40);
        check_val("t5_old", 32'(log_at(rd_log, 0)), 32'h77);
        check_val("t5_new", 32'(log_at(rd_log, 1)), 32'h3C);
        check_val("t5_order", 32'(log_at(gnt_log, 1)), 32'h1);

        // Reset during RDATA: rvalid lost, MEM intact
        clear_logs();
        rst_mode = 2; rst_fired = 1'b0;
        q_push(0, mk(0, 5, 0));
        drain(20);
        check_val("t6_rst_fired", 32'(rst_fired), 32'h1);
        check_val("t6_no_rvalid", 32'(rd_log.size()), 32'h0);
        rst_n = 1'b1;
        q_push(0, mk(0, 5, 0));
        drain(20);
        check_val("t6_reread", 32'(log_at(rd_log, 0)), 32'hA5);

        // req dropped right after being sampled: latched command still executes
        clear_logs();
        glitch = 1'b1;
        q_push(1, mk(1, 20, 8'hC3));
        drain(20);
        check_val("t7_gnt", 32'(log_at(gnt_log, 0)), 32'h1);
        q_push(1, mk(0, 20, 0));
        drain(20);
        check_val("t7_rd", 32'(log_at(rd_log, 0)), 32'hC3);

        // Random staggered traffic against the reference model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q_size(i) < 3 && $urandom_range(0, 3) == 0)
                    q_push(i, mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                                 int'($urandom_range(0, 255))));
            end
            run_cycle();
        end
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit reached, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
